// File: rtl/mips_defs.sv
// Shared MIPS encodings used by the write-back stage.
package mips_defs;

    localparam logic [5:0] SPECIAL    = 6'h00;
    localparam logic [5:0] JAL        = 6'h03;
    localparam logic [5:0] LB         = 6'h20;
    localparam logic [5:0] LH         = 6'h21;
    localparam logic [5:0] LW         = 6'h23;
    localparam logic [5:0] LBU        = 6'h24;
    localparam logic [5:0] LHU        = 6'h25;
    localparam logic [5:0] FUNCT_JALR = 6'h09;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic is_load(input logic [5:0] op);
        return (op == LW) || (op == LB) || (op == LBU) || (op == LH) || (op == LHU);
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load data lane select and sign/zero extension.
// Latency: combinational.
// Backpressure: none.
module load_ext
    import mips_defs::*;
(
    input  logic [31:0] DM_W,
    input  logic [3:0]  BE_W,
    input  logic [5:0]  opcode,
    output logic [31:0] ext_data
);

    logic [7:0]  lane_b;
    logic        lane_b_ok;
    logic [15:0] lane_h;
    logic        lane_h_ok;

    always_comb begin
        lane_b    = DM_W[7:0];
        lane_b_ok = 1'b1;
        case (BE_W)
            BE_B0:   lane_b = DM_W[7:0];
            BE_B1:   lane_b = DM_W[15:8];
            BE_B2:   lane_b = DM_W[23:16];
            BE_B3:   lane_b = DM_W[31:24];
            default: lane_b_ok = 1'b0;
        endcase
    end

    always_comb begin
        lane_h    = DM_W[15:0];
        lane_h_ok = 1'b1;
        case (BE_W)
            BE_H0:   lane_h = DM_W[15:0];
            BE_H1:   lane_h = DM_W[31:16];
            default: lane_h_ok = 1'b0;
        endcase
    end

    // An enable pattern that does not fit the access size leaves the word untouched.
    always_comb begin
        ext_data = DM_W;
        case (opcode)
            LB:  if (lane_b_ok) ext_data = {{24{lane_b[7]}}, lane_b};
            LBU: if (lane_b_ok) ext_data = {24'd0, lane_b};
            LH:  if (lane_h_ok) ext_data = {{16{lane_h[15]}}, lane_h};
            LHU: if (lane_h_ok) ext_data = {16'd0, lane_h};
            default: ext_data = DM_W;
        endcase
    end

endmodule

// File: rtl/writeback_grf.sv
// MIPS WB stage: write-back select, 32x32 register file with write bypass, retired counter.
// Latency: register write visible 1 cycle later (same cycle through bypass); reads combinational.
// Backpressure: none, one instruction accepted every cycle.
module writeback_grf
    import mips_defs::*;
#(
    parameter bit BYPASS_EN = 1'b1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_W,
    input  logic [31:0]      PC8_W,
    input  logic [31:0]      ALUout_W,
    input  logic [31:0]      DM_W,
    input  logic [3:0]       BE_W,
    input  logic [4:0]       write_register_W,
    input  logic             RegWrite_W,
    input  logic [4:0]       rs_addr_D,
    input  logic [4:0]       rt_addr_D,
    output logic [31:0]      rs_data_D,
    output logic [31:0]      rt_data_D,
    output logic [31:0]      wb_data,
    output logic             wb_we,
    output logic [CNT_W-1:0] retired_count
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] load_data;
    logic [31:0] regs [32];

    assign opcode = IR_W[31:26];
    assign funct  = IR_W[5:0];

    load_ext u_load_ext (
        .DM_W     (DM_W),
        .BE_W     (BE_W),
        .opcode   (opcode),
        .ext_data (load_data)
    );

    always_comb begin
        if (is_load(opcode)) begin
            wb_data = load_data;
        end else if ((opcode == JAL) || ((opcode == SPECIAL) && (funct == FUNCT_JALR))) begin
            wb_data = PC8_W;
        end else begin
            wb_data = ALUout_W;
        end
    end

    assign wb_we = RegWrite_W && (write_register_W != REG_ZERO);

    // regs[0] is never written; the read muxes force $0 to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[write_register_W] <= wb_data;
        end
    end

    always_comb begin
        if (rs_addr_D == REG_ZERO) begin
            rs_data_D = '0;
        end else if (BYPASS_EN && wb_we && (rs_addr_D == write_register_W)) begin
            rs_data_D = wb_data;
        end else begin
            rs_data_D = regs[rs_addr_D];
        end
    end

    always_comb begin
        if (rt_addr_D == REG_ZERO) begin
            rt_data_D = '0;
        end else if (BYPASS_EN && wb_we && (rt_addr_D == write_register_W)) begin
            rt_data_D = wb_data;
        end else begin
            rt_data_D = regs[rt_addr_D];
        end
    end

    // Bubbles (IR_W == 0) do not count; wraps silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= '0;
        end else if (IR_W != 32'd0) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_grf.sv
// Scoreboard bench for writeback_grf: directed plan cases followed by random traffic.
module tb_writeback_grf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR_W = '0, PC8_W = '0, ALUout_W = '0, DM_W = '0;
    logic [3:0]  BE_W = '0;
    logic [4:0]  write_register_W = '0, rs_addr_D = '0, rt_addr_D = '0;
    logic        RegWrite_W = 1'b0;
    logic [31:0] rs_data_D, rt_data_D, wb_data, retired_count;
    logic        wb_we;

    writeback_grf #(.BYPASS_EN(1'b1), .CNT_W(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .IR_W             (IR_W),
        .PC8_W            (PC8_W),
        .ALUout_W         (ALUout_W),
        .DM_W             (DM_W),
        .BE_W             (BE_W),
        .write_register_W (write_register_W),
        .RegWrite_W       (RegWrite_W),
        .rs_addr_D        (rs_addr_D),
        .rt_addr_D        (rt_addr_D),
        .rs_data_D        (rs_data_D),
        .rt_data_D        (rt_data_D),
        .wb_data          (wb_data),
        .wb_we            (wb_we),
        .retired_count    (retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wbd;
        logic        we;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model for the selected write-back value.
    function automatic logic [31:0] ref_sel(input logic [31:0] ir, input logic [31:0] pc8,
                                            input logic [31:0] alu, input logic [31:0] dm,
                                            input logic [3:0] be);
        logic [5:0]  op;
        logic [31:0] v;
        int          k;
        int          j;
        op = ir[31:26];
        k  = -1;
        for (int i = 0; i < 4; i++) if (be == (4'b0001 << i)) k = i;
        j  = (be == 4'b0011) ? 0 : (be == 4'b1100) ? 1 : -1;
        case (op)
            6'h23: return dm;
            6'h20, 6'h24: begin
                if (k < 0) return dm;
                v = (dm >> (8 * k)) & 32'hFF;
                if (op == 6'h20 && v >= 32'd128) v = v - 32'd256;
                return v;
            end
            6'h21, 6'h25: begin
                if (j < 0) return dm;
                v = (dm >> (16 * j)) & 32'hFFFF;
                if (op == 6'h21 && v >= 32'd32768) v = v - 32'd65536;
                return v;
            end
            6'h03: return pc8;
            6'h00: return (ir[5:0] == 6'h09) ? pc8 : alu;
            default: return alu;
        endcase
    endfunction

    task automatic drive(input logic rst, input logic [31:0] ir, input logic [31:0] pc8,
                         input logic [31:0] alu, input logic [31:0] dm, input logic [3:0] be,
                         input logic [4:0] wreg, input logic we, input logic [4:0] ra,
                         input logic [4:0] rb);
        exp_t e;
        @(posedge clk);
        #2;
        reset = rst; IR_W = ir; PC8_W = pc8; ALUout_W = alu; DM_W = dm; BE_W = be;
        write_register_W = wreg; RegWrite_W = we; rs_addr_D = ra; rt_addr_D = rb;
        e.wbd = ref_sel(ir, pc8, alu, dm, be);
        e.we  = we && (wreg != 5'd0);
        e.rs  = (ra == 5'd0) ? 32'd0 : (e.we && ra == wreg) ? e.wbd : m_regs[ra];
        e.rt  = (rb == 5'd0) ? 32'd0 : (e.we && rb == wreg) ? e.wbd : m_regs[rb];
        e.cnt = m_cnt;
        sb_q.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt = '0;
        end else begin
            if (e.we) m_regs[wreg] = e.wbd;
            if (ir != 32'd0) m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("wb_data", wb_data, e.wbd);
            chk("wb_we", {31'd0, wb_we}, {31'd0, e.we});
            chk("rs_data_D", rs_data_D, e.rs);
            chk("rt_data_D", rt_data_D, e.rt);
            chk("retired_count", retired_count, e.cnt);
        end
    end

    function automatic logic [31:0] rand_ir();
        logic [5:0] ops [8];
        logic [31:0] r;
        ops = '{6'h00, 6'h03, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h0D};
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 7)];
        if (r[31:26] == 6'h00) r[5:0] = ($urandom_range(0, 1) == 1) ? 6'h09 : 6'h21;
        if ($urandom_range(0, 9) == 0) r = 32'd0;
        return r;
    endfunction

    localparam logic [31:0] ADDU = 32'h0109_4021;
    localparam logic [31:0] DMV  = 32'h80FF_7F01;

    initial begin
        logic [3:0] bes [7];
        bes = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b0000};
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = '0;

        // reset state and ALU write with bypass
        drive(0, 0, 0, 0, 0, 0, 0, 0, 5, 31);
        drive(0, ADDU, 0, 32'h1234_5678, 0, 0, 8, 1, 8, 8);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
        // load extensions
        drive(0, {6'h20, 26'h0}, 0, 0, DMV, 4'b0010, 9, 1, 9, 8);
        drive(0, {6'h20, 26'h0}, 0, 0, DMV, 4'b1000, 9, 1, 9, 9);
        drive(0, {6'h24, 26'h0}, 0, 0, DMV, 4'b1000, 11, 1, 11, 9);
        drive(0, {6'h21, 26'h0}, 0, 0, DMV, 4'b1100, 12, 1, 12, 11);
        drive(0, {6'h25, 26'h0}, 0, 0, DMV, 4'b1100, 13, 1, 13, 12);
        drive(0, {6'h21, 26'h0}, 0, 0, DMV, 4'b0110, 14, 1, 14, 13);
        drive(0, {6'h20, 26'h0}, 0, 0, DMV, 4'b0000, 15, 1, 15, 14);
        drive(0, {6'h23, 26'h0}, 0, 0, DMV, 4'b1111, 16, 1, 16, 15);
        // jal / jalr
        drive(0, {6'h03, 26'h0C02}, 32'h0000_3008, 32'hAAAA_0000, 0, 0, 31, 1, 31, 16);
        drive(0, 32'h03E0_2009, 32'h0000_4444, 32'hBBBB_0000, 0, 0, 4, 1, 4, 31);
        // $0 write
        drive(0, ADDU, 0, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // counter: reset, 3 retire, bubble, 2 retire
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            drive(0, (i == 3) ? 32'd0 : ADDU, 0, i, 0, 0, 5'd20 + 5'(i), 1, 20, 21);
        // reset with a concurrent write to reg 10, then read it back
        drive(0, ADDU, 0, 32'h0000_0077, 0, 0, 10, 1, 10, 10);
        drive(1, ADDU, 0, 32'h0000_0055, 0, 0, 10, 1, 10, 10);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 10, 10);

        // random traffic, occasional mid-stream reset
        for (int n = 0; n < 500; n++) begin
            drive(($urandom_range(0, 49) == 0), rand_ir(), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 5) == 0) ? 4'($urandom) : bes[$urandom_range(0, 6)],
                  5'($urandom), 1'($urandom), 5'($urandom), 5'($urandom));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_grf.md
Name: writeback_grf

Overview:
- WB stage of the 5-stage MIPS pipeline, fed directly by the MEM/WB pipeline register outputs.
- Selects write-back data from ALU result, load data (byte/half extended) or link address.
- Writes the 32x32 general register file; D stage reads it through two read ports.
- Includes same-cycle write-to-read bypass and a retired-instruction counter.

Parameters:
- BYPASS_EN, 1, 1 = read ports return the write-back value when the read address matches the write address this cycle.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- IR_W  in  32  instruction in WB
- PC8_W  in  32  link address (PC+8) for jal/jalr
- ALUout_W  in  32  ALU result / effective address
- DM_W  in  32  raw word read from data memory
- BE_W  in  4  byte enables of the load access
- write_register_W  in  5  destination register number
- RegWrite_W  in  1  write enable
- rs_addr_D  in  5  read port A address
- rt_addr_D  in  5  read port B address
- rs_data_D  out  32  read port A data
- rt_data_D  out  32  read port B data
- wb_data  out  32  selected write-back value, also used for forwarding
- wb_we  out  1  effective write: RegWrite_W and write_register_W != 0
- retired_count  out  CNT_W  count of non-bubble instructions that reached WB

Behaviour:
- Reset: reset and clk are as already decided (synchronous, active-high; clock clk).
  - At posedge with reset=1, registers 1..31 clear to 0 and retired_count clears to 0.
  - Reset wins over a write in the same cycle.
  - rs_data_D, rt_data_D and wb_data are combinational, so they read 0 once registers clear, except while bypass is active.
- Data select (combinational):
  - Opcode IR_W[31:26] in {lw 0x23, lb 0x20, lbu 0x24, lh 0x21, lhu 0x25}: load path.
  - jal (0x03), or SPECIAL (0x00) with funct 0x09 (jalr): PC8_W.
  - Otherwise: ALUout_W.
- Load extension:
  - lb/lbu take the byte lane given by one-hot BE_W (0001 = [7:0], 0010 = [15:8], 0100 = [23:16], 1000 = [31:24]).
  - lh/lhu take BE_W 0011 = [15:0], 1100 = [31:16].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes DM_W unchanged.
  - An illegal BE_W for the opcode, or BE_W = 0, passes DM_W unchanged.
- Register write:
  - At posedge, if wb_we=1 and reset=0, regs[write_register_W] <= wb_data.
  - Latency is 1 cycle. $0 is never written and always reads 0.
- Read ports:
  - Combinational reads of the array.
  - With BYPASS_EN=1: if wb_we=1 and addr == write_register_W (addr != 0), return wb_data instead of the stored value. Both ports bypass independently; both may hit the same address.
  - With BYPASS_EN=0: return the stored value (old value until the edge).
- retired_count:
  - Increments by 1 at posedge when IR_W != 0 and reset=0.
  - Wraps from all-ones to 0 with no flag.
- RegWrite_W=1 with write_register_W=0: no write, wb_we=0, the counter still counts.
- Reset asserted in the middle of a stream: the instruction in WB that cycle is discarded, neither written nor counted.

Decomposition:
- Shared package mips_defs: opcode constants (LW, LB, LBU, LH, LHU, JAL, SPECIAL), FUNCT_JALR, the BE one-hot lane constants, and REG_ZERO=5'd0.
- Sub-module load_ext (combinational): inputs DM_W, BE_W and opcode; output the extended word.
- The register array, bypass and counter stay in writeback_grf.

Test Plan:
- Reset, then read rs=5, rt=31 -> both 0; retired_count=0.
- ALU write: IR=addu, ALUout=0x12345678, reg=8, RegWrite=1 -> same cycle rs_addr_D=8 returns 0x12345678 (bypass); next cycle the stored value is 0x12345678.
- lb, DM=0x80FF7F01, BE=0010, reg=9 -> 0xFFFFFF7F... byte [15:8]=0x7F, so 0x0000007F; with BE=1000 -> 0xFFFFFF80; lbu BE=1000 -> 0x00000080; lh BE=1100 -> 0xFFFF80FF; lhu BE=1100 -> 0x000080FF.
- jal, PC8=0x00003008, reg=31 -> reg31=0x00003008; jalr funct 0x09, reg=4 -> reg4=PC8.
- Write to $0 with value 0xDEADBEEF, RegWrite=1 -> wb_we=0; a read of $0 stays 0; retired_count still increments.
- Counter: 3 non-zero IRs, 1 bubble (IR=0), 2 non-zero -> retired_count=5. Then assert reset in the same cycle as a write to reg 10 -> reg10=0, count=0.
